// File: rtl/true2bcd_if.sv
// Handshake and result bundle between the calculator core and the
// sign-magnitude to BCD converter feeding the 7-segment drivers.
interface true2bcd_if #(
  parameter int IN_W   = 18,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [IN_W-1:0]       datain;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic [DIGITS-1:0]     blank;

  // Requester side: issues start/datain, observes the converted result.
  modport master (
    output start, datain,
    input  busy, done, bcd, neg, blank
  );

  // Converter side.
  modport slave (
    input  start, datain,
    output busy, done, bcd, neg, blank
  );
endinterface

// File: rtl/true2bcd.sv
// Serial double-dabble (shift-add-3) converter: one magnitude bit per clock.
// Takes an IN_W-bit sign-magnitude value and produces DIGITS packed BCD
// digits, a negative flag and a leading-zero blank mask. Result outputs only
// change on the done pulse, so the display never sees partial digits.
module true2bcd #(
  parameter int IN_W   = 18,
  parameter int DIGITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  true2bcd_if.slave  bus
);

  localparam int MAG_W = IN_W - 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + MAG_W;
  localparam int CNT_W = $clog2(MAG_W);

  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(MAG_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]        state;
  logic [SR_W-1:0]   sr;          // {BCD field, remaining binary bits}
  logic [CNT_W-1:0]  cnt;
  logic              neg_pend;    // sign of the value in flight, zero-qualified
  logic              busy_q;
  logic              done_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              neg_q;
  logic [DIGITS-1:0] blank_q;

  logic [SR_W-1:0]   adj;
  logic [SR_W-1:0]   shifted;
  logic [BCD_W-1:0]  next_bcd;
  logic [DIGITS-1:0] next_blank;
  logic              zero_run;

  // Add-3 to every BCD nibble >= 5, then shift; blank mask from the result.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned, which would otherwise infer a latch.
    adj        = sr;
    next_blank = '0;
    zero_run   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[MAG_W + 4*i +: 4] >= 4'd5)
        adj[MAG_W + 4*i +: 4] = sr[MAG_W + 4*i +: 4] + 4'd3;
    end
    shifted  = adj << 1;
    next_bcd = shifted[SR_W-1 -: BCD_W];
    // A digit is blank only if it and every digit above it are zero;
    // the units digit is always shown.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (next_bcd[4*i +: 4] == 4'd0);
      next_blank[i] = zero_run;
    end
  end

  // Control FSM, shift register and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      neg_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      blank_q  <= BLANK_RST;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr       <= {{BCD_W{1'b0}}, bus.datain[MAG_W-1:0]};
            neg_pend <= bus.datain[IN_W-1] & (|bus.datain[MAG_W-1:0]);
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          sr  <= shifted;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            bcd_q   <= next_bcd;
            neg_q   <= neg_pend;
            blank_q <= next_blank;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.blank = blank_q;

endmodule

// File: tb/tb_true2bcd.sv
// Directed bench for true2bcd: hand-computed BCD results, latency, busy
// length, start-while-busy, start-in-done-cycle and mid-conversion reset.
module tb_true2bcd;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  true2bcd_if #(.IN_W(18), .DIGITS(6)) bus ();

  true2bcd #(.IN_W(18), .DIGITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the next posedge (edge T).
  // Returns at the negedge right after edge T (window 0). datain is then
  // scrambled to show it no longer matters.
  task automatic start_conv(input logic [17:0] d);
    bus.start  = 1'b1;
    bus.datain = d;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.datain = 18'h3FFFF;
  endtask

  // Walk negedges from the current window until done is seen (bounded).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [23:0] e_bcd,
                              input logic e_neg, input logic [5:0] e_blank);
    check({tag, ".bcd"},   32'(bus.bcd),   32'(e_bcd));
    check({tag, ".neg"},   32'(bus.neg),   32'(e_neg));
    check({tag, ".blank"}, 32'(bus.blank), 32'(e_blank));
  endtask

  task automatic convert(input string tag, input logic [17:0] d,
                         input logic [23:0] e_bcd, input logic e_neg,
                         input logic [5:0] e_blank);
    int lat, bcnt;
    start_conv(d);
    wait_done(lat, bcnt);
    check({tag, ".latency"}, 32'(lat), 32'd17);
    check_result(tag, e_bcd, e_neg, e_blank);
  endtask

  initial begin
    int lat, bcnt, ndone;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.datain = '0;

    repeat (3) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check_result("rst", 24'h000000, 1'b0, 6'b111110);
    rst_n = 1'b1;
    @(negedge clk);

    // Input 16: latency, busy length and single-cycle done.
    start_conv(18'h00010);
    wait_done(lat, bcnt);
    check("p16.latency", 32'(lat), 32'd17);
    check("p16.busy_cycles", 32'(bcnt), 32'd17);
    check("p16.busy_in_done", 32'(bus.busy), 32'd0);
    check_result("p16", 24'h000016, 1'b0, 6'b111100);
    @(negedge clk);
    check("p16.done_width", 32'(bus.done), 32'd0);
    check_result("p16.hold", 24'h000016, 1'b0, 6'b111100);

    convert("m128",    18'h20080, 24'h000128, 1'b1, 6'b111000);
    convert("negzero", 18'h20000, 24'h000000, 1'b0, 6'b111110);
    convert("max",     18'h1FFFF, 24'h131071, 1'b0, 6'b000000);
    convert("zero",    18'h00000, 24'h000000, 1'b0, 6'b111110);
    convert("p9",      18'h00009, 24'h000009, 1'b0, 6'b111110);
    convert("m99999",  18'h3869F, 24'h099999, 1'b1, 6'b100000);

    // Start while busy is ignored.
    @(negedge clk);
    start_conv(18'h00080);
    repeat (5) @(negedge clk);
    bus.start  = 1'b1;
    bus.datain = 18'h00010;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(lat, bcnt);
    check("hs.latency", 32'(lat), 32'd11);
    check_result("hs", 24'h000128, 1'b0, 6'b111000);

    // Start in the done cycle is accepted.
    start_conv(18'h00010);
    check("hs2.busy", 32'(bus.busy), 32'd1);
    check_result("hs2.hold", 24'h000128, 1'b0, 6'b111000);
    wait_done(lat, bcnt);
    check("hs2.latency", 32'(lat), 32'd17);
    check_result("hs2", 24'h000016, 1'b0, 6'b111100);

    // No queued conversion afterwards.
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("hs.no_extra_done", 32'(ndone), 32'd0);

    // Reset mid-conversion aborts immediately.
    start_conv(18'h1FFFF);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", 32'(bus.busy), 32'd0);
    check("rstmid.done", 32'(bus.done), 32'd0);
    check_result("rstmid", 24'h000000, 1'b0, 6'b111110);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("rstmid.no_done", 32'(ndone), 32'd0);
    convert("post_rst", 18'h00010, 24'h000016, 1'b0, 6'b111100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
